// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: addresses, mstatus bit positions and layout.
package pipes;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Only MIE, MPIE and MPP hold state; everything else reads back 0.
    localparam logic [63:0] MSTATUS_WMASK = (64'd1 << MSTATUS_MIE)
                                          | (64'd1 << MSTATUS_MPIE)
                                          | (64'd1 << MSTATUS_MPP_LO)
                                          | (64'd1 << MSTATUS_MPP_HI);

    typedef struct packed {
        logic [50:0] rsv_63_13;
        logic [1:0]  mpp;
        logic [2:0]  rsv_10_8;
        logic        mpie;
        logic [2:0]  rsv_6_4;
        logic        mie;
        logic [2:0]  rsv_2_0;
    } mstatus_t;

endpackage

// File: rtl/csr_file_if.sv
// Pipeline <-> CSR file bus: read port, write port, trap/mret and redirect.
interface csr_file_if;
    logic [11:0] ra;
    logic [63:0] rdata;
    logic        rillegal;
    logic        wvalid;
    logic [11:0] wa;
    logic [63:0] wdata;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic        mret_valid;
    logic        retire;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] mstatus_o;

    modport master (
        output ra, wvalid, wa, wdata, trap_valid, trap_pc, trap_cause, trap_tval,
               mret_valid, retire,
        input  rdata, rillegal, redirect_valid, redirect_pc, mstatus_o
    );

    modport slave (
        input  ra, wvalid, wa, wdata, trap_valid, trap_pc, trap_cause, trap_tval,
               mret_valid, retire,
        output rdata, rillegal, redirect_valid, redirect_pc, mstatus_o
    );
endinterface

// File: rtl/csr_file_counter.sv
// 64-bit free-running counter; a load beats the increment, wraps silently.
module csr_counter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [63:0] q
);
    // load has precedence over increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  q <= '0;
        else if (we)  q <= wdata;
        else if (inc) q <= q + 64'd1;
    end
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap entry / mret and fetch redirect.
// Optional mcycle/minstret counters built when CSR_COUNTERS_EN is defined;
// otherwise 0xB00/0xB02 read as legal zeros and writes are dropped.
module csr_file
    import pipes::*;
(
    input  logic       clk,
    input  logic       resetn,
    csr_file_if.slave  bus
);
    mstatus_t    mstatus_q;
    logic [63:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

    // trap and mret both swallow a concurrent CSR write
    logic wr_en;
    assign wr_en = bus.wvalid & ~bus.trap_valid & ~bus.mret_valid;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
    logic        unused_pc0;
    assign unused_pc0 = bus.trap_pc[0];

    csr_counter u_mcycle (
        .clk   (clk),
        .resetn(resetn),
        .inc   (1'b1),
        .we    (wr_en && bus.wa == CSR_MCYCLE),
        .wdata (bus.wdata),
        .q     (mcycle_q)
    );

    csr_counter u_minstret (
        .clk   (clk),
        .resetn(resetn),
        .inc   (bus.retire),
        .we    (wr_en && bus.wa == CSR_MINSTRET),
        .wdata (bus.wdata),
        .q     (minstret_q)
    );
`else
    logic unused_in;
    assign unused_in = ^{bus.retire, bus.trap_pc[0]};
`endif

    // architectural CSR state: trap > mret > write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (bus.trap_valid) begin
            mepc_q         <= {bus.trap_pc[63:1], 1'b0};
            mcause_q       <= bus.trap_cause;
            mtval_q        <= bus.trap_tval;
            mstatus_q.mpie <= mstatus_q.mie;
            mstatus_q.mie  <= 1'b0;
            mstatus_q.mpp  <= 2'b11;
        end else if (bus.mret_valid) begin
            mstatus_q.mie  <= mstatus_q.mpie;
            mstatus_q.mpie <= 1'b1;
            mstatus_q.mpp  <= 2'b00;
        end else if (wr_en) begin
            case (bus.wa)
                CSR_MSTATUS:  mstatus_q  <= mstatus_t'(bus.wdata & MSTATUS_WMASK);
                CSR_MIE:      mie_q      <= bus.wdata;
                CSR_MTVEC:    mtvec_q    <= {bus.wdata[63:2], 1'b0, bus.wdata[0]};
                CSR_MSCRATCH: mscratch_q <= bus.wdata;
                CSR_MEPC:     mepc_q     <= {bus.wdata[63:1], 1'b0};
                CSR_MCAUSE:   mcause_q   <= bus.wdata;
                CSR_MTVAL:    mtval_q    <= bus.wdata;
                default:      ;
            endcase
        end
    end

    // one-cycle redirect pulse, target sampled from pre-update state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
        end else begin
            bus.redirect_valid <= bus.trap_valid | bus.mret_valid;
            if (bus.trap_valid)
                bus.redirect_pc <= {mtvec_q[63:2], 2'b00};
            else if (bus.mret_valid)
                bus.redirect_pc <= mepc_q;
        end
    end

    // combinational read of current state, no write bypass
    always_comb begin
        bus.rdata    = '0;
        bus.rillegal = 1'b0;
        case (bus.ra)
            CSR_MSTATUS:  bus.rdata = mstatus_q;
            CSR_MIE:      bus.rdata = mie_q;
            CSR_MTVEC:    bus.rdata = mtvec_q;
            CSR_MSCRATCH: bus.rdata = mscratch_q;
            CSR_MEPC:     bus.rdata = mepc_q;
            CSR_MCAUSE:   bus.rdata = mcause_q;
            CSR_MTVAL:    bus.rdata = mtval_q;
            CSR_MIP:      bus.rdata = '0;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:   bus.rdata = mcycle_q;
            CSR_MINSTRET: bus.rdata = minstret_q;
`else
            CSR_MCYCLE:   bus.rdata = '0;
            CSR_MINSTRET: bus.rdata = '0;
`endif
            default:      bus.rillegal = 1'b1;
        endcase
    end

    assign bus.mstatus_o = mstatus_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file; counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    csr_file_if bus();

    csr_file dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a);
        bus.ra = a;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        bus.wvalid = 1'b1;
        bus.wa     = a;
        bus.wdata  = d;
        step();
        bus.wvalid = 1'b0;
    endtask

    logic [11:0] impl [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02};

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.ra = '0; bus.wvalid = 1'b0; bus.wa = '0; bus.wdata = '0;
        bus.trap_valid = 1'b0; bus.trap_pc = '0; bus.trap_cause = '0; bus.trap_tval = '0;
        bus.mret_valid = 1'b0; bus.retire = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // reset state, read before any rising edge
        foreach (impl[i]) begin
            rd(impl[i]);
            chk($sformatf("rst_rd_%h", impl[i]), bus.rdata, 64'd0);
            chk($sformatf("rst_ill_%h", impl[i]), {63'd0, bus.rillegal}, 64'd0);
        end
        rd(12'h7C0);
        chk("unimpl_rdata", bus.rdata, 64'd0);
        chk("unimpl_rill", {63'd0, bus.rillegal}, 64'd1);
        chk("rst_redir_v", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst_redir_pc", bus.redirect_pc, 64'd0);

        // mtvec write, same-cycle read sees old value
        bus.ra = 12'h305; bus.wvalid = 1'b1; bus.wa = 12'h305; bus.wdata = 64'h8000_0003;
        #1;
        chk("mtvec_same_cyc", bus.rdata, 64'd0);
        step();
        bus.wvalid = 1'b0;
        rd(12'h305);
        chk("mtvec_masked", bus.rdata, 64'h8000_0001);

        // mstatus write mask
        wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h300);
        chk("mstatus_wmask", bus.rdata, 64'h1888);
        wr(12'h300, 64'h8);
        chk("mstatus_o_mie", bus.mstatus_o, 64'h8);

        // mip ignored, mepc bit0 cleared, unimplemented write dropped
        wr(12'h344, 64'hFFF);
        rd(12'h344);
        chk("mip_ro0", bus.rdata, 64'd0);
        wr(12'h341, 64'h123);
        rd(12'h341);
        chk("mepc_bit0", bus.rdata, 64'h122);
        wr(12'h7C0, 64'h55);
        rd(12'h340);
        chk("unimpl_wr_drop", bus.rdata, 64'd0);

        // trap with a concurrent write that must be dropped
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h8000_0102;
        bus.trap_cause = 64'd2; bus.trap_tval = 64'hDEAD;
        bus.wvalid = 1'b1; bus.wa = 12'h340; bus.wdata = 64'd7;
        step();
        bus.trap_valid = 1'b0; bus.wvalid = 1'b0;
        chk("trap_redir_v", {63'd0, bus.redirect_valid}, 64'd1);
        chk("trap_redir_pc", bus.redirect_pc, 64'h8000_0000);
        rd(12'h341); chk("trap_mepc", bus.rdata, 64'h8000_0102);
        rd(12'h342); chk("trap_mcause", bus.rdata, 64'd2);
        rd(12'h343); chk("trap_mtval", bus.rdata, 64'hDEAD);
        rd(12'h300); chk("trap_mstatus", bus.rdata, 64'h1880);
        rd(12'h340); chk("trap_wr_drop", bus.rdata, 64'd0);
        step();
        chk("trap_pulse_end", {63'd0, bus.redirect_valid}, 64'd0);

        // mret with a concurrent write that must be dropped
        bus.mret_valid = 1'b1;
        bus.wvalid = 1'b1; bus.wa = 12'h340; bus.wdata = 64'd5;
        step();
        bus.mret_valid = 1'b0; bus.wvalid = 1'b0;
        chk("mret_redir_v", {63'd0, bus.redirect_valid}, 64'd1);
        chk("mret_redir_pc", bus.redirect_pc, 64'h8000_0102);
        rd(12'h300); chk("mret_mstatus", bus.rdata, 64'h88);
        rd(12'h340); chk("mret_wr_drop", bus.rdata, 64'd0);
        step();
        chk("mret_pulse_end", {63'd0, bus.redirect_valid}, 64'd0);

        // odd trap pc has bit0 cleared
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h4001; bus.trap_cause = 64'd5; bus.trap_tval = 64'd0;
        step();
        bus.trap_valid = 1'b0;
        rd(12'h341); chk("trap_pc_bit0", bus.rdata, 64'h4000);
        rd(12'h300); chk("trap2_mstatus", bus.rdata, 64'h1880);
        step();

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'hB00); chk("mcycle_load", bus.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("mcycle_wrap", bus.rdata, 64'd0);
        step();
        chk("mcycle_inc", bus.rdata, 64'd1);
        bus.retire = 1'b1;
        wr(12'hB02, 64'd10);
        bus.retire = 1'b0;
        rd(12'hB02); chk("minstret_wr_prec", bus.rdata, 64'd10);
        bus.retire = 1'b1;
        step();
        bus.retire = 1'b0;
        chk("minstret_retire", bus.rdata, 64'd11);
        step();
        chk("minstret_hold", bus.rdata, 64'd11);
`else
        wr(12'hB00, 64'd5);
        rd(12'hB00);
        chk("mcycle_off_rd", bus.rdata, 64'd0);
        chk("mcycle_off_ill", {63'd0, bus.rillegal}, 64'd0);
        bus.retire = 1'b1;
        wr(12'hB02, 64'd9);
        bus.retire = 1'b0;
        rd(12'hB02);
        chk("minstret_off_rd", bus.rdata, 64'd0);
`endif

        // reset right after trap edge cancels redirect and clears mepc
        rd(12'h341);
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h5000;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        bus.trap_valid = 1'b0;
        @(negedge clk);
        chk("rst_cancel_v", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst_cancel_mepc", bus.rdata, 64'd0);
        resetn = 1'b1;
        step();
        chk("post_rst_v", {63'd0, bus.redirect_valid}, 64'd0);
`ifdef CSR_COUNTERS_EN
        rd(12'hB00);
        chk("mcycle_first_inc", bus.rdata, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
